// File: rtl/wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_ctrl_pkg
//   Shared types and constants for the writeback controller slice.
//   - Register-file address/data widths and zero/enable constants.
//   - WbQDepth: depth of the long-latency result queue.
//   - wb_entry_t: one queued write {waddr, wdata}.
//   - wb_src_e: which source owns the write port in a given cycle.
// -----------------------------------------------------------------------------
package wb_ctrl_pkg;

  localparam int RegAddrW = 5;
  localparam int RegW     = 32;
  localparam int WbQDepth = 2;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [RegW-1:0]     reg_data_t;

  localparam reg_data_t ZeroWord    = '0;
  localparam reg_addr_t ZeroReg     = '0;
  localparam logic      RstEnable   = 1'b0;
  localparam logic      WriteEnable = 1'b1;

  typedef struct packed {
    reg_addr_t waddr;
    reg_data_t wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,   // nothing to write this cycle
    SRC_EX,     // single-cycle ALU result
    SRC_QUEUE,  // head of the long-result queue
    SRC_LU      // long result written straight through an empty queue
  } wb_src_e;

  // x0 is hardwired to zero, so writes to it and scoreboard entries for it
  // are meaningless.
  function automatic logic is_nonzero(input reg_addr_t a);
    return a != ZeroReg;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_ctrl_if
//   Groups every non-clock signal of the writeback controller.
//   slave  : the controller side (wb_ctrl).
//   master : the pipeline side (ex, long units, id, register file).
//   Signals:
//     ex_*      ALU result, never back-pressured
//     lu_*      long-unit result valid/ready handshake
//     iss_*     long-latency issue, sets a scoreboard bit
//     raddr1/2  id source registers, stall_o answers for them
//     wb_hold_o ask ex to drop ex_valid_i so the queue can drain
//     we/waddr/wdata  registered register-file write port
// -----------------------------------------------------------------------------
interface wb_ctrl_if
  import wb_ctrl_pkg::*;
;

  logic      ex_valid_i;
  reg_addr_t ex_waddr_i;
  reg_data_t ex_wdata_i;

  logic      lu_valid_i;
  logic      lu_ready_o;
  reg_addr_t lu_waddr_i;
  reg_data_t lu_wdata_i;

  logic      iss_valid_i;
  reg_addr_t iss_rd_i;

  reg_addr_t raddr1_i;
  reg_addr_t raddr2_i;
  logic      stall_o;

  logic      wb_hold_o;

  logic      we_o;
  reg_addr_t waddr_o;
  reg_data_t wdata_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lu_valid_i, lu_waddr_i, lu_wdata_i,
    output lu_ready_o,
    input  iss_valid_i, iss_rd_i,
    input  raddr1_i, raddr2_i,
    output stall_o, wb_hold_o,
    output we_o, waddr_o, wdata_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lu_valid_i, lu_waddr_i, lu_wdata_i,
    input  lu_ready_o,
    output iss_valid_i, iss_rd_i,
    output raddr1_i, raddr2_i,
    input  stall_o, wb_hold_o,
    input  we_o, waddr_o, wdata_o
  );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Two-entry FIFO of {waddr, wdata} holding long-latency results that lost
//   write-port arbitration.
//   Ports:
//     clk, rst  clock, asynchronous active-low reset (empties the FIFO)
//     push, din entry to append (ignored when full unless popping too)
//     pop       remove the head (ignored when empty)
//     full, empty, head  status and current head entry
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PtrW = $clog2(WbQDepth);
  localparam int CntW = $clog2(WbQDepth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntFull = cnt_t'(WbQDepth);

  wb_entry_t mem [WbQDepth];
  ptr_t      rd_ptr;
  ptr_t      wr_ptr;
  cnt_t      count;
  logic      do_push;
  logic      do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntFull);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; count gates
  // every read of it, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl
//   Owns the single write port of the integer register file. Each cycle the
//   ALU result wins the port; otherwise the oldest long-latency result is
//   written. Long results that cannot be written immediately wait in a
//   two-entry queue (wb_fifo). A long result arriving at an empty queue with
//   no ALU write goes straight to the port, giving it the same one-edge
//   latency as the ALU path.
//   A busy scoreboard tracks destinations of issued long ops so id can stall
//   on RAW hazards; a bit clears on the edge its result is written, and the
//   register file's write bypass covers that cycle.
//   A starvation counter raises wb_hold_o when queued results have been held
//   off by ALU writes for STARVE_LIM consecutive cycles.
//   Ports:
//     clk  clock
//     rst  asynchronous active-low reset
//     bus  wb_ctrl_if.slave, see the interface for the signal list
// -----------------------------------------------------------------------------
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input logic        clk,
  input logic        rst,
  wb_ctrl_if.slave   bus
);

  localparam int StarveW = $clog2(STARVE_LIM + 1);
  typedef logic [StarveW-1:0] starve_t;
  localparam starve_t StarveMax = starve_t'(STARVE_LIM);

  // Queue interface
  logic      q_push;
  logic      q_pop;
  logic      q_full;
  logic      q_empty;
  wb_entry_t q_head;
  wb_entry_t lu_entry;

  // Arbitration
  logic      ex_wr;
  logic      lu_push;
  logic      lu_bypass;
  wb_src_e   wr_src;
  wb_entry_t wr_entry;

  // Scoreboard and starvation
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  starve_t     starve_cnt;
  starve_t     starve_nxt;

  // Registered outputs
  logic      we_q;
  reg_addr_t waddr_q;
  reg_data_t wdata_q;
  logic      hold_q;

  assign lu_entry = '{waddr: bus.lu_waddr_i, wdata: bus.lu_wdata_i};

  assign ex_wr          = bus.ex_valid_i && is_nonzero(bus.ex_waddr_i);
  assign bus.lu_ready_o = !q_full;
  // A handshake to x0 completes but carries nothing worth writing.
  assign lu_push        = bus.lu_valid_i && bus.lu_ready_o && is_nonzero(bus.lu_waddr_i);

  // Queue empty and port free: write the incoming long result directly
  // instead of parking it for a cycle.
  assign lu_bypass = lu_push && q_empty && !ex_wr;
  assign q_push    = lu_push && !lu_bypass;
  assign q_pop     = !q_empty && !ex_wr;

  wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (lu_entry),
    .pop   (q_pop),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  // Queued results are older than a newly arriving one, so the queue head is
  // preferred over the bypass to keep long writes in acceptance order.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_src   = SRC_NONE;
    wr_entry = '{waddr: ZeroReg, wdata: ZeroWord};
    if (ex_wr) begin
      wr_src   = SRC_EX;
      wr_entry = '{waddr: bus.ex_waddr_i, wdata: bus.ex_wdata_i};
    end else if (!q_empty) begin
      wr_src   = SRC_QUEUE;
      wr_entry = q_head;
    end else if (lu_bypass) begin
      wr_src   = SRC_LU;
      wr_entry = lu_entry;
    end
  end

  // Clear first, then set, so a re-issue of the register being written
  // keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_src == SRC_QUEUE || wr_src == SRC_LU) begin
      busy_nxt[wr_entry.waddr] = 1'b0;
    end
    if (bus.iss_valid_i && is_nonzero(bus.iss_rd_i)) begin
      busy_nxt[bus.iss_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // A non-empty queue that is not popping is being blocked by an ALU write.
  always_comb begin
    starve_nxt = starve_cnt;
    if (q_empty || q_pop) begin
      starve_nxt = '0;
    end else if (starve_cnt != StarveMax) begin
      starve_nxt = starve_cnt + starve_t'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      we_q       <= 1'b0;
      waddr_q    <= ZeroReg;
      wdata_q    <= ZeroWord;
      hold_q     <= 1'b0;
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      busy       <= busy_nxt;
      starve_cnt <= starve_nxt;
      hold_q     <= (starve_nxt >= StarveMax);
      if (wr_src != SRC_NONE) begin
        we_q    <= WriteEnable;
        waddr_q <= wr_entry.waddr;
        wdata_q <= wr_entry.wdata;
      end else begin
        we_q    <= !WriteEnable;
      end
    end
  end

  assign bus.we_o      = we_q;
  assign bus.waddr_o   = waddr_q;
  assign bus.wdata_o   = wdata_q;
  assign bus.wb_hold_o = hold_q;

  assign bus.stall_o = (is_nonzero(bus.raddr1_i) && busy[bus.raddr1_i]) ||
                       (is_nonzero(bus.raddr2_i) && busy[bus.raddr2_i]);

endmodule

// File: tb/tb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl
//   Directed vectors for wb_ctrl with hand-computed expected values.
//   Inputs change 1 ns after a rising edge; registered outputs are sampled
//   there, combinational outputs 1 ns after the inputs change.
// -----------------------------------------------------------------------------
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_ctrl_if bus ();

  wb_ctrl #(.STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid_i  = 1'b0;
    bus.ex_waddr_i  = '0;
    bus.ex_wdata_i  = '0;
    bus.lu_valid_i  = 1'b0;
    bus.lu_waddr_i  = '0;
    bus.lu_wdata_i  = '0;
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i    = '0;
    bus.raddr1_i    = '0;
    bus.raddr2_i    = '0;
  endtask

  task automatic set_ex(input logic v, input reg_addr_t a, input reg_data_t d);
    bus.ex_valid_i = v;
    bus.ex_waddr_i = a;
    bus.ex_wdata_i = d;
  endtask

  task automatic set_lu(input logic v, input reg_addr_t a, input reg_data_t d);
    bus.lu_valid_i = v;
    bus.lu_waddr_i = a;
    bus.lu_wdata_i = d;
  endtask

  task automatic check_wr(input string tag, input logic we, input reg_addr_t a, input reg_data_t d);
    check({tag, ".we"},    32'(bus.we_o),    32'(we));
    check({tag, ".waddr"}, 32'(bus.waddr_o), 32'(a));
    check({tag, ".wdata"}, bus.wdata_o,      d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b0;

    // Reset state
    tick();
    tick();
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.hold",  32'(bus.wb_hold_o),  32'd0);
    check("rst.ready", 32'(bus.lu_ready_o), 32'd1);
    bus.raddr1_i = 5'd7;
    #1;
    check("rst.stall", 32'(bus.stall_o), 32'd0);
    bus.raddr1_i = '0;
    rst = 1'b1;
    tick();

    // ALU only
    set_ex(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    set_ex(1'b1, 5'd0, 32'h11111111);
    tick();
    check_wr("alu_x0", 1'b0, 5'd5, 32'hDEADBEEF);
    idle();

    // Long write-back with scoreboard
    bus.iss_valid_i = 1'b1;
    bus.iss_rd_i    = 5'd7;
    tick();
    bus.iss_valid_i = 1'b0;
    bus.raddr1_i    = 5'd7;
    #1;
    check("sb.stall_r1", 32'(bus.stall_o), 32'd1);
    bus.raddr1_i = 5'd0;
    bus.raddr2_i = 5'd7;
    #1;
    check("sb.stall_r2", 32'(bus.stall_o), 32'd1);
    bus.raddr1_i = 5'd7;
    bus.raddr2_i = 5'd0;
    set_lu(1'b1, 5'd7, 32'h1234);
    #1;
    check("long.ready", 32'(bus.lu_ready_o), 32'd1);
    tick();
    check_wr("long", 1'b1, 5'd7, 32'h1234);
    check("long.stall_clr", 32'(bus.stall_o), 32'd0);
    idle();

    // Collision: ALU first, long next
    set_ex(1'b1, 5'd3, 32'hA);
    set_lu(1'b1, 5'd4, 32'hB);
    #1;
    check("col.ready0", 32'(bus.lu_ready_o), 32'd1);
    tick();
    check_wr("col.alu", 1'b1, 5'd3, 32'hA);
    idle();
    #1;
    check("col.ready1", 32'(bus.lu_ready_o), 32'd1);
    tick();
    check_wr("col.long", 1'b1, 5'd4, 32'hB);
    tick();
    check_wr("col.idle", 1'b0, 5'd4, 32'hB);

    // Full queue, starvation, saturation, drain
    set_ex(1'b1, 5'd1, 32'h100);
    set_lu(1'b1, 5'd12, 32'hC1);
    tick();                                  // enqueue C1, queue was empty
    check_wr("full.w0", 1'b1, 5'd1, 32'h100);
    set_ex(1'b1, 5'd2, 32'h101);
    set_lu(1'b1, 5'd13, 32'hC2);
    #1;
    check("full.ready1", 32'(bus.lu_ready_o), 32'd1);
    tick();                                  // blocked 1, enqueue C2
    set_lu(1'b0, 5'd0, 32'h0);
    #1;
    check("full.ready0", 32'(bus.lu_ready_o), 32'd0);
    check("full.hold1", 32'(bus.wb_hold_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, 5'(i + 1), 32'h102 + 32'(i));
      tick();                                // blocked 2, 3
    end
    check_wr("full.w3", 1'b1, 5'd2, 32'h103);
    check("full.hold3", 32'(bus.wb_hold_o), 32'd0);
    set_ex(1'b1, 5'd1, 32'h104);
    tick();                                  // blocked 4
    check("full.hold4", 32'(bus.wb_hold_o), 32'd1);
    check_wr("full.w4", 1'b1, 5'd1, 32'h104);
    set_ex(1'b1, 5'd2, 32'h105);
    tick();                                  // saturated
    check("full.hold_sat", 32'(bus.wb_hold_o), 32'd1);
    idle();
    tick();
    check_wr("drain.c1", 1'b1, 5'd12, 32'hC1);
    check("drain.hold", 32'(bus.wb_hold_o), 32'd0);
    tick();
    check_wr("drain.c2", 1'b1, 5'd13, 32'hC2);
    check("drain.ready", 32'(bus.lu_ready_o), 32'd1);
    tick();
    check_wr("drain.idle", 1'b0, 5'd13, 32'hC2);

    // Same-cycle issue and write of rd=9: the set wins
    bus.iss_valid_i = 1'b1;
    bus.iss_rd_i    = 5'd9;
    set_lu(1'b1, 5'd9, 32'hD9);
    tick();
    check_wr("setwin", 1'b1, 5'd9, 32'hD9);
    idle();
    bus.raddr2_i = 5'd9;
    #1;
    check("setwin.stall", 32'(bus.stall_o), 32'd1);

    // ex_valid to x0 does not block a queued pop; the pop clears busy[9]
    set_ex(1'b1, 5'd6, 32'h66);
    set_lu(1'b1, 5'd9, 32'h99);
    tick();
    check_wr("x0pop.alu", 1'b1, 5'd6, 32'h66);
    check("x0pop.stall_held", 32'(bus.stall_o), 32'd1);
    set_lu(1'b0, 5'd0, 32'h0);
    set_ex(1'b1, 5'd0, 32'h77);
    tick();
    check_wr("x0pop.long", 1'b1, 5'd9, 32'h99);
    check("x0pop.stall_clr", 32'(bus.stall_o), 32'd0);
    idle();

    // Long handshake to x0 is accepted and discarded
    set_lu(1'b1, 5'd0, 32'h5);
    #1;
    check("lu_x0.ready", 32'(bus.lu_ready_o), 32'd1);
    tick();
    check("lu_x0.we", 32'(bus.we_o), 32'd0);
    idle();
    tick();
    check("lu_x0.we2", 32'(bus.we_o), 32'd0);

    // Reset while the queue holds two entries
    bus.iss_valid_i = 1'b1;
    bus.iss_rd_i    = 5'd20;
    tick();
    bus.iss_rd_i    = 5'd21;
    tick();
    bus.iss_valid_i = 1'b0;
    set_ex(1'b1, 5'd1, 32'h201);
    set_lu(1'b1, 5'd20, 32'hE0);
    tick();
    set_ex(1'b1, 5'd2, 32'h202);
    set_lu(1'b1, 5'd21, 32'hE1);
    tick();
    idle();
    bus.raddr1_i = 5'd20;
    bus.raddr2_i = 5'd21;
    #1;
    check("prerst.ready", 32'(bus.lu_ready_o), 32'd0);
    check("prerst.stall", 32'(bus.stall_o), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst.we",    32'(bus.we_o),       32'd0);
    check("midrst.ready", 32'(bus.lu_ready_o), 32'd1);
    check("midrst.stall", 32'(bus.stall_o),    32'd0);
    check("midrst.hold",  32'(bus.wb_hold_o),  32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst.we", 32'(bus.we_o), 32'd0);
    end
    check("postrst.stall", 32'(bus.stall_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller that owns the single write port of the integer register file. It merges single-cycle ALU results from ex with results from multi-cycle units (divider, load unit) through a 2-entry result queue, and drives registered `we`/`waddr`/`wdata` into the register file. It also keeps a busy scoreboard of destination registers with long-latency results in flight, so that id can stall on read-after-write hazards. The register file's same-cycle write bypass covers the cycle in which a busy bit clears.

## Interface
Parameters:
- `STARVE_LIM`, default 4: consecutive cycles a queued long result may be blocked by ALU writes before `wb_hold_o` asserts.

Ports:
- `clk`  in  1  clock; everything is updated on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low (`rst == RstEnable` means in reset).
- `ex_valid_i`  in  1  ALU result valid this cycle. It is never back-pressured.
- `ex_waddr_i`  in  5  ALU destination register.
- `ex_wdata_i`  in  32  ALU result.
- `lu_valid_i`  in  1  long-unit result valid.
- `lu_ready_o`  out  1  long-unit result accepted (combinational: queue not full).
- `lu_waddr_i`  in  5  long-unit destination register.
- `lu_wdata_i`  in  32  long-unit result.
- `iss_valid_i`  in  1  a long-latency op is issued this cycle.
- `iss_rd_i`  in  5  destination register of the issued op.
- `raddr1_i`, `raddr2_i`  in  5 each  id read addresses to check against the scoreboard.
- `stall_o`  out  1  combinational: id must stall because a source register is busy.
- `wb_hold_o`  out  1  registered: ex must drop `ex_valid_i` next cycle so the queue can drain.
- `we_o`  out  1  register-file write enable (registered).
- `waddr_o`  out  5  register-file write address (registered).
- `wdata_o`  out  32  register-file write data (registered).

## Operation
- Reset values: `we_o`=0, `waddr_o`=0, `wdata_o`=0, `wb_hold_o`=0, queue empty, all busy bits 0, starvation counter 0. Under reset, `lu_ready_o`=1 and `stall_o`=0.
- Definitions:
  - `ex_wr` = `ex_valid_i` && `ex_waddr_i`≠0.
  - `push` = `lu_valid_i` && `lu_ready_o` && `lu_waddr_i`≠0.
  - A long-unit handshake with `lu_waddr_i`=0 is accepted and discarded.
- Queue: 2-entry FIFO of {waddr, wdata}. `lu_ready_o` = count<2. It may push and pop in the same cycle, including when full; with count=2, `lu_ready_o` stays 0 regardless of a pop.
- Write-port arbitration each cycle, ALU first:
  - If `ex_wr`, register the ALU write.
  - Otherwise, if the queue is non-empty, pop the head and register its write.
  - Otherwise, `we_o` goes low next cycle; `waddr_o`/`wdata_o` hold their values.
  - `ex_valid_i` with x0 does not block the pop.
- Scoreboard: `busy[31:1]` (x0 is never busy).
  - Set: `iss_valid_i` && `iss_rd_i`≠0 sets `busy[iss_rd_i]`.
  - Clear: a pop clears `busy[head.waddr]` on the same edge that `we_o` is registered.
  - Set and clear of the same register in one cycle: the set wins.
- `stall_o` = (`raddr1_i`≠0 && `busy[raddr1_i]`) || (`raddr2_i`≠0 && `busy[raddr2_i]`).
- Starvation counter:
  - Increments when the queue is non-empty and `ex_wr` blocks the pop.
  - Resets to 0 on a pop, or when the queue is empty.
  - `wb_hold_o` <= (next counter ≥ `STARVE_LIM`).
  - The counter saturates at `STARVE_LIM`.
- Ordering: long results are written in acceptance order. A later ALU write may overtake a queued long write to a different register. ALU writes to a busy register are illegal; issue logic guarantees this never happens.

## Timing
- ALU path latency: 1 cycle (`ex_valid_i` at edge N gives `we_o` high after edge N).
- Long path latency: 1 cycle from handshake to `we_o` if the queue is empty and there is no `ex_wr`; otherwise 1 + blocked cycles.
- The busy bit drops on the same edge that `we_o` rises, so a dependent read sees the result through the register-file bypass with no bubble.
- Reset asserted mid-operation clears the queue, scoreboard and outputs immediately (asynchronously). Queued results are lost; upstream is flushed by the same reset.

## Structure
- `defines.v` supplies `RegAddrBus`, `RegBus`, `ZeroWord`, `ZeroReg`, `RstEnable`, `WriteEnable`.
- Add `WbQDepth` (2) to `defines.v`.
- Sub-module `wb_fifo`: 2-entry {5-bit addr, 32-bit data} FIFO with push/pop/full/empty/head, using the same `clk`/`rst`.
- Scoreboard, arbitration and starvation counter live in `wb_ctrl`.

## Test plan
- ALU only: `ex_valid_i`=1, waddr=5, wdata=0xDEADBEEF → next cycle `we_o`=1, `waddr_o`=5, `wdata_o`=0xDEADBEEF; x0 target → `we_o`=0.
- Long write-back: issue rd=7 → `stall_o`=1 for `raddr1_i`=7. Push {7, 0x1234} with no ALU write → next cycle `we_o`=1, `waddr_o`=7; `busy[7]`=0 and `stall_o`=0 in that same cycle.
- Collision: ALU {3, 0xA} and long {4, 0xB} in the same cycle → write 3 then 4 on consecutive cycles; `lu_ready_o` stays 1.
- Full queue: two pushes during continuous `ex_wr` → `lu_ready_o`=0. After 4 blocked cycles, `wb_hold_o`=1. Drop `ex_valid_i` → two pops in order, then `wb_hold_o`=0.
- Same-cycle issue rd=9 and pop of {9, data} → write occurs and `busy[9]` remains 1.
- Assert `rst` while the queue holds 2 entries → next cycles show `we_o`=0, `lu_ready_o`=1, `stall_o`=0, and no stale writes after reset release.
